// File: rtl/regfile_pkg.sv
// regfile_pkg: shared helpers for the regfile_bank register file slice.
package regfile_pkg;

  // Widest exchange-flop vector the remap helper accepts.
  localparam int MAX_PAIRS = 32;

  // True when the bus split and the exchange window both fit inside the file.
  function automatic bit params_ok(input int width, input int nregs, input int nleft,
                                   input int npairs, input int pair_base);
    return (width > 32'sd0) && (nregs > 32'sd0) && (npairs > 32'sd0) &&
           (npairs <= MAX_PAIRS) && (nleft <= nregs) && (pair_base >= nleft) &&
           (pair_base + 32'sd2 * npairs <= nregs);
  endfunction

  // Logical register index -> physical register index under the given exchange flops.
  function automatic int remap(input int idx, input logic [MAX_PAIRS-1:0] swap_state,
                               input int pair_base, input int npairs);
    int rel;
    int res;
    logic [MAX_PAIRS-1:0] shifted;
    rel     = idx - pair_base;
    res     = idx;
    shifted = {MAX_PAIRS{1'b0}};
    if ((rel >= 32'sd0) && (rel < 32'sd2 * npairs)) begin
      shifted = swap_state >> (rel / 32'sd2);
      if (shifted[0]) begin
        res = ((rel % 32'sd2) == 32'sd0) ? (idx + 32'sd1) : (idx - 32'sd1);
      end else begin
        res = idx;
      end
    end else begin
      res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_bus_resolve.sv
// regfile_bus_resolve: wired-AND of an optional driver and a masked set of
// register words. An undriven bus with nothing selected floats to all ones.
module regfile_bus_resolve
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 14
) (
  input  logic [N-1:0]           mask,
  input  logic [N-1:0][WIDTH-1:0] words,
  input  logic                   words_en,
  input  logic                   drv_en,
  input  logic [WIDTH-1:0]       drv_data,
  output logic [WIDTH-1:0]       bus
);

  logic [WIDTH-1:0] acc_s;

  // AND together the driver (if enabled) and every selected word (if enabled).
  always_comb begin
    acc_s = drv_en ? drv_data : {WIDTH{1'b1}};
    for (int i = 0; i < N; i++) begin
      acc_s = acc_s & ((words_en && mask[i]) ? words[i] : {WIDTH{1'b1}});
    end
  end

  assign bus = acc_s;

endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: WIDTH x NREGS register file on two wired-AND buses that can be
// joined or split, with per-pair exchange flops remapping logical selects.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NREGS     = 14,
  parameter int NLEFT     = 2,
  parameter int NPAIRS    = 4,
  parameter int PAIR_BASE = 6
) (
  input  logic              eclk,
  input  logic              erst,
  input  logic              join_en,
  input  logic [NREGS-1:0]  sel,
  input  logic              l_wr,
  input  logic [WIDTH-1:0]  l_din,
  input  logic              r_wr,
  input  logic [WIDTH-1:0]  r_din,
  input  logic [NPAIRS-1:0] swap,
  output logic [WIDTH-1:0]  l_dout,
  output logic [WIDTH-1:0]  r_dout,
  output logic [NPAIRS-1:0] swap_state
);

  if (!params_ok(WIDTH, NREGS, NLEFT, NPAIRS, PAIR_BASE)) begin : g_param_check
    $error("regfile_bank: illegal WIDTH/NREGS/NLEFT/NPAIRS/PAIR_BASE combination");
  end

  logic [NREGS-1:0][WIDTH-1:0] regs_r;
  logic [MAX_PAIRS-1:0]        swap_ext_s;
  logic [NREGS-1:0]            phys_sel_s;
  logic [NREGS-1:0]            left_mask_s;
  logic [WIDTH-1:0]            join_drv_s;
  logic [WIDTH-1:0]            join_bus_s;
  logic [WIDTH-1:0]            left_bus_s;
  logic [WIDTH-1:0]            right_bus_s;
  logic [WIDTH-1:0]            l_bus_s;
  logic [WIDTH-1:0]            r_bus_s;
  logic                        l_we_s;
  logic                        r_we_s;

  // Translate logical selects to physical ones using the pre-edge exchange flops.
  always_comb begin
    swap_ext_s                = {MAX_PAIRS{1'b0}};
    swap_ext_s[NPAIRS-1:0]    = swap_state;
    phys_sel_s                = {NREGS{1'b0}};
    left_mask_s               = {NREGS{1'b0}};
    for (int p = 0; p < NREGS; p++) begin
      left_mask_s[p] = (p < NLEFT);
      for (int i = 0; i < NREGS; i++) begin
        phys_sel_s[p] = phys_sel_s[p] |
                        (sel[i] && (remap(i, swap_ext_s, PAIR_BASE, NPAIRS) == p));
      end
    end
  end

  // Combined driver for the joined bus: both write ports AND onto one wire.
  always_comb begin
    join_drv_s = (l_wr ? l_din : {WIDTH{1'b1}}) & (r_wr ? r_din : {WIDTH{1'b1}});
  end

  regfile_bus_resolve #(.WIDTH(WIDTH), .N(NREGS)) u_join (
    .mask     (phys_sel_s),
    .words    (regs_r),
    .words_en (!(l_wr || r_wr)),
    .drv_en   (l_wr || r_wr),
    .drv_data (join_drv_s),
    .bus      (join_bus_s)
  );

  regfile_bus_resolve #(.WIDTH(WIDTH), .N(NREGS)) u_left (
    .mask     (phys_sel_s & left_mask_s),
    .words    (regs_r),
    .words_en (!l_wr),
    .drv_en   (l_wr),
    .drv_data (l_din),
    .bus      (left_bus_s)
  );

  regfile_bus_resolve #(.WIDTH(WIDTH), .N(NREGS)) u_right (
    .mask     (phys_sel_s & ~left_mask_s),
    .words    (regs_r),
    .words_en (!r_wr),
    .drv_en   (r_wr),
    .drv_data (r_din),
    .bus      (right_bus_s)
  );

  // Pick joined or split bus values and decide which side may be written.
  always_comb begin
    if (join_en) begin
      l_bus_s = join_bus_s;
      r_bus_s = join_bus_s;
    end else begin
      l_bus_s = left_bus_s;
      r_bus_s = right_bus_s;
    end
    l_we_s = l_wr || (join_en && r_wr);
    r_we_s = r_wr || (join_en && l_wr);
  end

  // Write every selected physical register from the bus of its own side.
  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      regs_r <= '0;
    end else begin
      for (int p = 0; p < NREGS; p++) begin
        if (phys_sel_s[p] && left_mask_s[p] && l_we_s) begin
          regs_r[p] <= l_bus_s;
        end else if (phys_sel_s[p] && !left_mask_s[p] && r_we_s) begin
          regs_r[p] <= r_bus_s;
        end
      end
    end
  end

  // Capture both resolved bus values every cycle.
  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      l_dout <= {WIDTH{1'b0}};
      r_dout <= {WIDTH{1'b0}};
    end else begin
      l_dout <= l_bus_s;
      r_dout <= r_bus_s;
    end
  end

  // Toggle exchange flops on request; the new mapping applies from next cycle.
  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      swap_state <= {NPAIRS{1'b0}};
    end else begin
      swap_state <= swap_state ^ swap;
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed vector table, reset corner cases and randomized
// traffic checked against a behavioural model of the register file.
module tb_regfile_bank;

  localparam int W  = 16;
  localparam int N  = 14;
  localparam int NL = 2;
  localparam int NP = 4;
  localparam int PB = 6;

  logic          eclk = 1'b0;
  logic          erst;
  logic          join_en;
  logic [N-1:0]  sel;
  logic          l_wr;
  logic [W-1:0]  l_din;
  logic          r_wr;
  logic [W-1:0]  r_din;
  logic [NP-1:0] swap;
  logic [W-1:0]  l_dout;
  logic [W-1:0]  r_dout;
  logic [NP-1:0] swap_state;

  always #5 eclk = ~eclk;

  regfile_bank #(.WIDTH(W), .NREGS(N), .NLEFT(NL), .NPAIRS(NP), .PAIR_BASE(PB)) dut (
    .eclk       (eclk),
    .erst       (erst),
    .join_en    (join_en),
    .sel        (sel),
    .l_wr       (l_wr),
    .l_din      (l_din),
    .r_wr       (r_wr),
    .r_din      (r_din),
    .swap       (swap),
    .l_dout     (l_dout),
    .r_dout     (r_dout),
    .swap_state (swap_state)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [W-1:0]  m_regs [N];
  logic [NP-1:0] m_swap;
  logic [W-1:0]  m_l;
  logic [W-1:0]  m_r;

  typedef struct {
    bit            j;
    logic [N-1:0]  s;
    bit            lw;
    logic [W-1:0]  ld;
    bit            rw;
    logic [W-1:0]  rd;
    logic [NP-1:0] sw;
    logic [W-1:0]  el;
    logic [W-1:0]  er;
    logic [NP-1:0] es;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] b(input int i);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  function automatic vec_t v(bit j, logic [N-1:0] s, bit lw, logic [W-1:0] ld, bit rw,
                             logic [W-1:0] rd, logic [NP-1:0] sw, logic [W-1:0] el,
                             logic [W-1:0] er, logic [NP-1:0] es);
    vec_t t;
    t = '{j, s, lw, ld, rw, rd, sw, el, er, es};
    return t;
  endfunction

  // Logical index to physical index: an exchanged pair trades places.
  function automatic int phys(input int i);
    if (i >= PB && i < PB + 2 * NP) begin
      if (m_swap[(i - PB) / 2]) return ((i - PB) % 2 == 0) ? i + 1 : i - 1;
    end
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_swap = '0;
    m_l    = '0;
    m_r    = '0;
  endtask

  // One clock edge of the model, computed from the spec's bus rules.
  task automatic model_edge(input bit j, input logic [N-1:0] s, input bit lw,
                            input logic [W-1:0] ld, input bit rw, input logic [W-1:0] rd,
                            input logic [NP-1:0] sw);
    logic [W-1:0] bus_l, bus_r;
    int p;
    bus_l = '1;
    bus_r = '1;
    if (j) begin
      if (lw) bus_l &= ld;
      if (rw) bus_l &= rd;
      if (!lw && !rw)
        for (int i = 0; i < N; i++) if (s[i]) bus_l &= m_regs[phys(i)];
      bus_r = bus_l;
    end else begin
      if (lw) bus_l = ld;
      else for (int i = 0; i < N; i++) if (s[i] && phys(i) < NL) bus_l &= m_regs[phys(i)];
      if (rw) bus_r = rd;
      else for (int i = 0; i < N; i++) if (s[i] && phys(i) >= NL) bus_r &= m_regs[phys(i)];
    end
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        p = phys(i);
        if (p < NL && (lw || (j && rw))) m_regs[p] = bus_l;
        if (p >= NL && (rw || (j && lw))) m_regs[p] = bus_r;
      end
    end
    m_swap ^= sw;
    m_l = bus_l;
    m_r = bus_r;
  endtask

  // Apply one cycle of inputs, advance the model, settle past the edge.
  task automatic drive(input bit j, input logic [N-1:0] s, input bit lw,
                       input logic [W-1:0] ld, input bit rw, input logic [W-1:0] rd,
                       input logic [NP-1:0] sw);
    join_en = j; sel = s; l_wr = lw; l_din = ld; r_wr = rw; r_din = rd; swap = sw;
    model_edge(j, s, lw, ld, rw, rd, sw);
    @(posedge eclk);
    #1;
  endtask

  initial begin
    erst = 1'b1; join_en = 1'b0; sel = '0; l_wr = 1'b0; l_din = '0;
    r_wr = 1'b0; r_din = '0; swap = '0;
    model_reset();
    @(posedge eclk);
    #1;
    chk("reset l_dout", l_dout, 16'h0000);
    chk("reset r_dout", r_dout, 16'h0000);
    chk("reset swap_state", swap_state, 4'h0);
    erst = 1'b0;

    //            j  sel            lw ld       rw rd       sw    l_dout   r_dout   swap
    tbl.push_back(v(0, b(6),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h0000, 4'h0));
    tbl.push_back(v(0, b(8),         0, 16'h0,    1, 16'h1234, 4'h0, 16'hFFFF, 16'h1234, 4'h0));
    tbl.push_back(v(0, b(8),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h1234, 4'h0));
    tbl.push_back(v(1, b(0) | b(3),  1, 16'hABCD, 0, 16'h0,    4'h0, 16'hABCD, 16'hABCD, 4'h0));
    tbl.push_back(v(0, b(0),         0, 16'h0,    0, 16'h0,    4'h0, 16'hABCD, 16'hFFFF, 4'h0));
    tbl.push_back(v(0, b(3),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'hABCD, 4'h0));
    tbl.push_back(v(0, b(8),         0, 16'h0,    1, 16'h0F0F, 4'h0, 16'hFFFF, 16'h0F0F, 4'h0));
    tbl.push_back(v(0, b(10),        0, 16'h0,    1, 16'h00FF, 4'h0, 16'hFFFF, 16'h00FF, 4'h0));
    tbl.push_back(v(0, b(8) | b(10), 0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h000F, 4'h0));
    tbl.push_back(v(0, b(6),         0, 16'h0,    1, 16'h1111, 4'h0, 16'hFFFF, 16'h1111, 4'h0));
    tbl.push_back(v(0, b(7),         0, 16'h0,    1, 16'h2222, 4'h0, 16'hFFFF, 16'h2222, 4'h0));
    tbl.push_back(v(0, b(6),         0, 16'h0,    0, 16'h0,    4'h1, 16'hFFFF, 16'h1111, 4'h1));
    tbl.push_back(v(0, b(6),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h2222, 4'h1));
    tbl.push_back(v(0, b(6),         0, 16'h0,    1, 16'h5555, 4'h0, 16'hFFFF, 16'h5555, 4'h1));
    tbl.push_back(v(0, b(6),         0, 16'h0,    0, 16'h0,    4'h1, 16'hFFFF, 16'h5555, 4'h0));
    tbl.push_back(v(0, b(6),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h1111, 4'h0));
    tbl.push_back(v(0, b(7),         0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'h5555, 4'h0));
    tbl.push_back(v(1, b(1),         1, 16'hFF00, 1, 16'h0FF0, 4'h0, 16'h0F00, 16'h0F00, 4'h0));
    tbl.push_back(v(0, b(1),         0, 16'h0,    0, 16'h0,    4'h0, 16'h0F00, 16'hFFFF, 4'h0));
    tbl.push_back(v(1, '0,           0, 16'h0,    0, 16'h0,    4'h0, 16'hFFFF, 16'hFFFF, 4'h0));
    tbl.push_back(v(1, b(1) | b(8),  0, 16'h0,    0, 16'h0,    4'h0, 16'h0F00, 16'h0F00, 4'h0));
    tbl.push_back(v(0, b(0) | b(1),  0, 16'h0,    0, 16'h0,    4'h0, 16'h0B00, 16'hFFFF, 4'h0));
    tbl.push_back(v(0, b(0) | b(9),  1, 16'h3C3C, 1, 16'hC3C3, 4'h0, 16'h3C3C, 16'hC3C3, 4'h0));
    tbl.push_back(v(0, b(0) | b(9),  0, 16'h0,    0, 16'h0,    4'h0, 16'h3C3C, 16'hC3C3, 4'h0));
    tbl.push_back(v(1, b(1),         0, 16'h0,    1, 16'h00F0, 4'h0, 16'h00F0, 16'h00F0, 4'h0));
    tbl.push_back(v(0, b(1),         0, 16'h0,    0, 16'h0,    4'h0, 16'h00F0, 16'hFFFF, 4'h0));
    tbl.push_back(v(0, '0,           0, 16'h0,    0, 16'h0,    4'hA, 16'hFFFF, 16'hFFFF, 4'hA));
    tbl.push_back(v(0, '0,           0, 16'h0,    0, 16'h0,    4'hA, 16'hFFFF, 16'hFFFF, 4'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].j, tbl[i].s, tbl[i].lw, tbl[i].ld, tbl[i].rw, tbl[i].rd, tbl[i].sw);
      chk($sformatf("vec%0d l_dout", i), l_dout, tbl[i].el);
      chk($sformatf("vec%0d r_dout", i), r_dout, tbl[i].er);
      chk($sformatf("vec%0d swap_state", i), swap_state, tbl[i].es);
    end

    // Mid-cycle reset: outputs clear at once, and a write pending across it is lost.
    drive(0, '0, 0, 16'h0, 0, 16'h0, 4'h5);
    chk("pre-reset swap_state", swap_state, 4'h5);
    #2;
    erst = 1'b1;
    #1;
    chk("async reset l_dout", l_dout, 16'h0000);
    chk("async reset r_dout", r_dout, 16'h0000);
    chk("async reset swap_state", swap_state, 4'h0);
    join_en = 1'b0; sel = b(8); r_wr = 1'b1; r_din = 16'h7777; swap = 4'hF;
    @(posedge eclk);
    #1;
    erst = 1'b0;
    model_reset();
    drive(0, b(6), 0, 16'h0, 0, 16'h0, 4'h0);
    chk("post-reset reg6", r_dout, 16'h0000);
    chk("post-reset swap_state", swap_state, 4'h0);
    drive(0, b(8), 0, 16'h0, 0, 16'h0, 4'h0);
    chk("write under reset discarded", r_dout, 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0]  s;
      logic [NP-1:0] sw;
      s  = N'($urandom & $urandom);
      sw = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      drive(1'($urandom_range(0, 1)), s, ($urandom_range(0, 2) == 0), W'($urandom),
            ($urandom_range(0, 2) == 0), W'($urandom), sw);
      chk($sformatf("rand%0d l_dout", n), l_dout, m_l);
      chk($sformatf("rand%0d r_dout", n), r_dout, m_r);
      chk($sformatf("rand%0d swap_state", n), swap_state, m_swap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
